// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: default widths and the
// memory access-size encodings used by the EX/MEM stage.
package mips_pkg;

   localparam int NB_REG     = 32;
   localparam int NB_ADDR    = 5;
   localparam int NB_BHW     = 2;
   localparam int NB_BYTE_EN = 4;

   // Access-size code carried with every load/store; 2'b10 is reserved
   // and behaves like a word access.
   typedef enum logic [NB_BHW-1:0] {
      BHW_BYTE = 2'b00,
      BHW_HALF = 2'b01,
      BHW_RSVD = 2'b10,
      BHW_WORD = 2'b11
   } bhw_e;

endpackage

// File: rtl/store_formatter.sv
// Combinational store formatter: replicates store data across the bus,
// builds byte-lane write enables and detects misaligned accesses.
module store_formatter
   import mips_pkg::*;
#(
   parameter int NB_DATA = NB_REG
) (
   input  logic [NB_DATA-1:0]    i_data,
   input  logic [NB_BHW-1:0]     i_bhw,
   input  logic [1:0]            i_addr,
   input  logic                  i_store,
   input  logic                  i_load,
   output logic [NB_DATA-1:0]    o_data,
   output logic [NB_BYTE_EN-1:0] o_byte_en,
   output logic                  o_misaligned
);

   logic [NB_BYTE_EN-1:0] w_lane_mask;
   logic                  w_fault;

   // Size decode: lane replication, raw lane mask and alignment rule.
   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      o_data      = i_data;
      w_lane_mask = 4'b1111;
      w_fault     = 1'b0;
      case (bhw_e'(i_bhw))
         BHW_BYTE: begin
            o_data      = {4{i_data[7:0]}};
            w_lane_mask = 4'b0001 << i_addr;
            w_fault     = 1'b0;
         end
         BHW_HALF: begin
            o_data      = {2{i_data[15:0]}};
            w_lane_mask = 4'b0011 << i_addr;
            w_fault     = i_addr[0];
         end
         default: begin
            // Word and the reserved code: full-width, 4-byte aligned.
            o_data      = i_data;
            w_lane_mask = 4'b1111;
            w_fault     = |i_addr;
         end
      endcase
   end

   // A fault only matters for a real memory access; a faulting store
   // must not touch any byte lane.
   always_comb begin
      o_misaligned = w_fault & (i_store | i_load);
      o_byte_en    = (i_store & ~w_fault) ? w_lane_mask : '0;
   end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures ALU result and store data, resolves
// conditional branches, formats stores, and handles stepping, flush and halt.
module ex_mem_reg
   import mips_pkg::*;
#(
   parameter int NB_REG  = mips_pkg::NB_REG,
   parameter int NB_ADDR = mips_pkg::NB_ADDR,
   parameter int NB_BHW  = mips_pkg::NB_BHW
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_enable,
   input  logic                  i_flush,
   input  logic                  i_valid,
   input  logic [NB_REG-1:0]     i_alu_result,
   input  logic [NB_REG-1:0]     i_store_data,
   input  logic [NB_ADDR-1:0]    i_write_reg,
   input  logic [NB_REG-1:0]     i_pc_branch,
   input  logic                  i_mem_read,
   input  logic                  i_mem_write,
   input  logic                  i_reg_write,
   input  logic                  i_mem_to_reg,
   input  logic                  i_branch,
   input  logic                  i_halt,
   input  logic [NB_BHW-1:0]     i_bhw,
   output logic [NB_REG-1:0]     o_alu_result,
   output logic [NB_REG-1:0]     o_store_data,
   output logic [NB_REG-1:0]     o_pc_branch,
   output logic [NB_ADDR-1:0]    o_write_reg,
   output logic                  o_mem_read,
   output logic                  o_mem_write,
   output logic                  o_reg_write,
   output logic                  o_mem_to_reg,
   output logic [NB_BYTE_EN-1:0] o_byte_en,
   output logic [NB_BHW-1:0]     o_bhw,
   output logic                  o_branch_taken,
   output logic                  o_misaligned,
   output logic                  o_valid,
   output logic                  o_halt
);

   // Control bits qualified by the valid flag.
   logic                  w_mem_read;
   logic                  w_mem_write;
   logic [NB_REG-1:0]     w_fmt_data;
   logic [NB_BYTE_EN-1:0] w_byte_en;
   logic                  w_misaligned;

   // Registered state, one register per output.
   logic [NB_REG-1:0]     r_alu_result;
   logic [NB_REG-1:0]     r_store_data;
   logic [NB_REG-1:0]     r_pc_branch;
   logic [NB_ADDR-1:0]    r_write_reg;
   logic                  r_mem_read;
   logic                  r_mem_write;
   logic                  r_reg_write;
   logic                  r_mem_to_reg;
   logic [NB_BYTE_EN-1:0] r_byte_en;
   logic [NB_BHW-1:0]     r_bhw;
   logic                  r_branch_taken;
   logic                  r_misaligned;
   logic                  r_valid;
   logic                  r_halt;

   assign w_mem_read  = i_valid & i_mem_read;
   assign w_mem_write = i_valid & i_mem_write;

   store_formatter #(
      .NB_DATA (NB_REG)
   ) u_store_formatter (
      .i_data       (i_store_data),
      .i_bhw        (i_bhw),
      .i_addr       (i_alu_result[1:0]),
      .i_store      (w_mem_write),
      .i_load       (w_mem_read),
      .o_data       (w_fmt_data),
      .o_byte_en    (w_byte_en),
      .o_misaligned (w_misaligned)
   );

   // Edge priority: reset, then frozen while halted, then stepping hold,
   // then bubble on flush, otherwise capture the EX stage.
   // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_alu_result   <= '0;
         r_store_data   <= '0;
         r_pc_branch    <= '0;
         r_write_reg    <= '0;
         r_mem_read     <= 1'b0;
         r_mem_write    <= 1'b0;
         r_reg_write    <= 1'b0;
         r_mem_to_reg   <= 1'b0;
         r_byte_en      <= '0;
         r_bhw          <= '0;
         r_branch_taken <= 1'b0;
         r_misaligned   <= 1'b0;
         r_valid        <= 1'b0;
         r_halt         <= 1'b0;
      end else if (r_halt || !i_enable) begin
         // Halted or stepping paused: hold everything, flush included.
      end else if (i_flush) begin
         r_alu_result   <= '0;
         r_store_data   <= '0;
         r_pc_branch    <= '0;
         r_write_reg    <= '0;
         r_mem_read     <= 1'b0;
         r_mem_write    <= 1'b0;
         r_reg_write    <= 1'b0;
         r_mem_to_reg   <= 1'b0;
         r_byte_en      <= '0;
         r_bhw          <= '0;
         r_branch_taken <= 1'b0;
         r_misaligned   <= 1'b0;
         r_valid        <= 1'b0;
         r_halt         <= 1'b0;
      end else begin
         r_alu_result   <= i_alu_result;
         r_store_data   <= w_fmt_data;
         r_pc_branch    <= i_pc_branch;
         r_write_reg    <= i_write_reg;
         // A misaligned access is suppressed before it reaches memory.
         r_mem_read     <= w_mem_read & ~w_misaligned;
         r_mem_write    <= w_mem_write & ~w_misaligned;
         r_reg_write    <= i_valid & i_reg_write;
         r_mem_to_reg   <= i_valid & i_mem_to_reg;
         r_byte_en      <= w_byte_en;
         r_bhw          <= i_bhw;
         // BEQ/BNE ALU codes leave 1 in bit 0 when the condition holds.
         r_branch_taken <= i_valid & i_branch & i_alu_result[0];
         r_misaligned   <= w_misaligned;
         r_valid        <= i_valid;
         r_halt         <= i_valid & i_halt;
      end
   end

   assign o_alu_result   = r_alu_result;
   assign o_store_data   = r_store_data;
   assign o_pc_branch    = r_pc_branch;
   assign o_write_reg    = r_write_reg;
   assign o_mem_read     = r_mem_read;
   assign o_mem_write    = r_mem_write;
   assign o_reg_write    = r_reg_write;
   assign o_mem_to_reg   = r_mem_to_reg;
   assign o_byte_en      = r_byte_en;
   assign o_bhw          = r_bhw;
   assign o_branch_taken = r_branch_taken;
   assign o_misaligned   = r_misaligned;
   assign o_valid        = r_valid;
   assign o_halt         = r_halt;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: behavioural model compared every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_ex_mem_reg;

   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] store_data;
      logic [31:0] pc_branch;
      logic [4:0]  write_reg;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic        mem_to_reg;
      logic [3:0]  byte_en;
      logic [1:0]  bhw;
      logic        branch_taken;
      logic        misaligned;
      logic        valid;
      logic        halt;
   } out_t;

   logic        clk = 1'b0;
   logic        i_reset, i_enable, i_flush, i_valid;
   logic [31:0] i_alu_result, i_store_data, i_pc_branch;
   logic [4:0]  i_write_reg;
   logic        i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg, i_branch, i_halt;
   logic [1:0]  i_bhw;
   logic [31:0] o_alu_result, o_store_data, o_pc_branch;
   logic [4:0]  o_write_reg;
   logic        o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg;
   logic [3:0]  o_byte_en;
   logic [1:0]  o_bhw;
   logic        o_branch_taken, o_misaligned, o_valid, o_halt;

   int   checks   = 0;
   int   failures = 0;
   out_t model;
   out_t dut_s;
   logic model_ok = 1'b0;

   ex_mem_reg dut (
      .i_clock        (clk),
      .i_reset        (i_reset),
      .i_enable       (i_enable),
      .i_flush        (i_flush),
      .i_valid        (i_valid),
      .i_alu_result   (i_alu_result),
      .i_store_data   (i_store_data),
      .i_write_reg    (i_write_reg),
      .i_pc_branch    (i_pc_branch),
      .i_mem_read     (i_mem_read),
      .i_mem_write    (i_mem_write),
      .i_reg_write    (i_reg_write),
      .i_mem_to_reg   (i_mem_to_reg),
      .i_branch       (i_branch),
      .i_halt         (i_halt),
      .i_bhw          (i_bhw),
      .o_alu_result   (o_alu_result),
      .o_store_data   (o_store_data),
      .o_pc_branch    (o_pc_branch),
      .o_write_reg    (o_write_reg),
      .o_mem_read     (o_mem_read),
      .o_mem_write    (o_mem_write),
      .o_reg_write    (o_reg_write),
      .o_mem_to_reg   (o_mem_to_reg),
      .o_byte_en      (o_byte_en),
      .o_bhw          (o_bhw),
      .o_branch_taken (o_branch_taken),
      .o_misaligned   (o_misaligned),
      .o_valid        (o_valid),
      .o_halt         (o_halt)
   );

   always #5 clk = ~clk;

   always_comb begin
      dut_s.alu_result   = o_alu_result;
      dut_s.store_data   = o_store_data;
      dut_s.pc_branch    = o_pc_branch;
      dut_s.write_reg    = o_write_reg;
      dut_s.mem_read     = o_mem_read;
      dut_s.mem_write    = o_mem_write;
      dut_s.reg_write    = o_reg_write;
      dut_s.mem_to_reg   = o_mem_to_reg;
      dut_s.byte_en      = o_byte_en;
      dut_s.bhw          = o_bhw;
      dut_s.branch_taken = o_branch_taken;
      dut_s.misaligned   = o_misaligned;
      dut_s.valid        = o_valid;
      dut_s.halt         = o_halt;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // What a captured instruction must look like, from the access rules.
   function automatic out_t load_model();
      out_t e;
      int   size;
      int   addr;
      logic rd, wr, mis;
      e    = '0;
      size = (i_bhw == 2'b00) ? 1 : (i_bhw == 2'b01) ? 2 : 4;
      addr = int'(i_alu_result[1:0]);
      rd   = i_valid & i_mem_read;
      wr   = i_valid & i_mem_write;
      mis  = (rd | wr) && ((addr % size) != 0);
      e.alu_result = i_alu_result;
      e.pc_branch  = i_pc_branch;
      e.write_reg  = i_write_reg;
      e.bhw        = i_bhw;
      if (size == 1)      e.store_data = {24'b0, i_store_data[7:0]} * 32'h0101_0101;
      else if (size == 2) e.store_data = {16'b0, i_store_data[15:0]} * 32'h0001_0001;
      else                e.store_data = i_store_data;
      e.mem_read     = rd & !mis;
      e.mem_write    = wr & !mis;
      e.misaligned   = mis;
      e.byte_en      = (wr && !mis) ? 4'(((1 << size) - 1) << addr) : 4'b0;
      e.reg_write    = i_valid & i_reg_write;
      e.mem_to_reg   = i_valid & i_mem_to_reg;
      e.branch_taken = i_valid & i_branch & i_alu_result[0];
      e.valid        = i_valid;
      e.halt         = i_valid & i_halt;
      return e;
   endfunction

   // Reference model advanced on every rising edge.
   always @(posedge clk) begin
      if (i_reset) begin
         model    <= '0;
         model_ok <= 1'b1;
      end else if (model.halt || !i_enable) begin
         model <= model;
      end else if (i_flush) begin
         model <= '0;
      end else begin
         model <= load_model();
      end
   end

   // Continuous comparison away from the active edge.
   always @(negedge clk) begin
      if (model_ok) check("cycle_model", 128'(dut_s), 128'(model));
   end

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [31:0] alu, input logic [31:0] data, input logic [1:0] bhw,
                            input logic rd, input logic wr, input logic rw, input logic br, input logic hlt);
      i_valid      = 1'b1;
      i_alu_result = alu;
      i_store_data = data;
      i_bhw        = bhw;
      i_mem_read   = rd;
      i_mem_write  = wr;
      i_reg_write  = rw;
      i_mem_to_reg = rd;
      i_branch     = br;
      i_halt       = hlt;
      i_pc_branch  = 32'h0000_0040;
      i_write_reg  = 5'd7;
   endtask

   task automatic randomize_ins();
      i_valid      = 1'($urandom);
      i_alu_result = $urandom;
      i_store_data = $urandom;
      i_pc_branch  = $urandom;
      i_write_reg  = 5'($urandom);
      i_mem_read   = 1'($urandom);
      i_mem_write  = 1'($urandom);
      i_reg_write  = 1'($urandom);
      i_mem_to_reg = 1'($urandom);
      i_branch     = 1'($urandom);
      i_halt       = 1'($urandom);
      i_bhw        = 2'($urandom);
   endtask

   initial begin
      // Reset held for two edges with busy inputs.
      i_reset = 1'b1; i_enable = 1'b1; i_flush = 1'b0;
      set_instr(32'hFFFF_FFFF, 32'h1234_5678, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      edge_step();
      edge_step();
      check("reset_all_zero", 128'(dut_s), 128'(0));
      i_reset = 1'b0; i_enable = 1'b0;
      edge_step();
      edge_step();
      check("disabled_after_reset", 128'(dut_s), 128'(0));

      // Byte store at 0x1003.
      i_enable = 1'b1;
      set_instr(32'h0000_1003, 32'hAABB_CCDD, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      edge_step();
      check("byte_store_data", 128'(o_store_data), 128'(32'hDDDD_DDDD));
      check("byte_store_en", 128'(o_byte_en), 128'(4'b1000));
      check("byte_store_wr", 128'(o_mem_write), 128'(1'b1));

      // Misaligned half store at 0x1001.
      set_instr(32'h0000_1001, 32'hAABB_CCDD, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      edge_step();
      check("half_mis_flag", 128'(o_misaligned), 128'(1'b1));
      check("half_mis_wr", 128'(o_mem_write), 128'(1'b0));
      check("half_mis_en", 128'(o_byte_en), 128'(4'b0000));

      // Aligned half store at 0x1002 uses the upper lanes.
      set_instr(32'h0000_1002, 32'hAABB_1234, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      edge_step();
      check("half_store_data", 128'(o_store_data), 128'(32'h1234_1234));
      check("half_store_en", 128'(o_byte_en), 128'(4'b1100));

      // Word load at 0x1004.
      set_instr(32'h0000_1004, 32'h0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      edge_step();
      check("word_load_mis", 128'(o_misaligned), 128'(1'b0));
      check("word_load_rd", 128'(o_mem_read), 128'(1'b1));
      check("word_load_en", 128'(o_byte_en), 128'(4'b0000));

      // Reserved size code behaves as word.
      set_instr(32'h0000_100A, 32'h0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      edge_step();
      check("rsvd_mis", 128'(o_misaligned), 128'(1'b1));
      check("rsvd_rd", 128'(o_mem_read), 128'(1'b0));

      // Branch resolution.
      set_instr(32'h0000_0001, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      edge_step();
      check("beq_taken", 128'(o_branch_taken), 128'(1'b1));
      check("beq_target", 128'(o_pc_branch), 128'(32'h0000_0040));
      set_instr(32'h0000_0000, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      edge_step();
      check("beq_not_taken", 128'(o_branch_taken), 128'(1'b0));
      set_instr(32'h0000_0001, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      i_valid = 1'b0;
      edge_step();
      check("beq_invalid", 128'(o_branch_taken), 128'(1'b0));
      check("invalid_valid", 128'(o_valid), 128'(1'b0));

      // Word store, then stepping paused with changing inputs.
      set_instr(32'h2000_0008, 32'h1122_3344, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      edge_step();
      check("word_store_data", 128'(o_store_data), 128'(32'h1122_3344));
      check("word_store_en", 128'(o_byte_en), 128'(4'b1111));
      i_enable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         randomize_ins();
         edge_step();
         check("hold_alu", 128'(o_alu_result), 128'(32'h2000_0008));
         check("hold_en", 128'(o_byte_en), 128'(4'b1111));
      end
      set_instr(32'h0000_3000, 32'h0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      i_enable = 1'b1;
      edge_step();
      check("resume_alu", 128'(o_alu_result), 128'(32'h0000_3000));
      check("resume_rw", 128'(o_reg_write), 128'(1'b1));
      check("resume_en", 128'(o_byte_en), 128'(4'b0000));

      // Flush while disabled is ignored.
      i_enable = 1'b0; i_flush = 1'b1; i_alu_result = 32'h0000_0999;
      edge_step();
      check("flush_disabled", 128'(o_alu_result), 128'(32'h0000_3000));

      // Flush beats a valid halt on the same edge.
      i_enable = 1'b1;
      set_instr(32'h0000_0044, 32'h0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      edge_step();
      check("flush_halt_bubble", 128'(dut_s), 128'(0));

      // Halt on the next edge, then freeze.
      i_flush = 1'b0;
      set_instr(32'h0000_0055, 32'h0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      edge_step();
      check("halt_set", 128'(o_halt), 128'(1'b1));
      check("halt_alu", 128'(o_alu_result), 128'(32'h0000_0055));
      for (int k = 0; k < 10; k++) begin
         randomize_ins();
         i_enable = 1'($urandom);
         i_flush  = 1'b1;
         edge_step();
         check("halt_frozen", 128'({o_halt, o_alu_result, o_reg_write}), 128'({1'b1, 32'h0000_0055, 1'b1}));
      end

      // Reset clears the halt, loading resumes next edge.
      i_reset = 1'b1;
      edge_step();
      check("reset_clears_halt", 128'(dut_s), 128'(0));
      i_reset = 1'b0; i_flush = 1'b0; i_enable = 1'b1;
      set_instr(32'h0000_0066, 32'h0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      edge_step();
      check("post_reset_load", 128'({o_alu_result, o_valid}), 128'({32'h0000_0066, 1'b1}));

      // A short random run against the model.
      for (int k = 0; k < 40; k++) begin
         randomize_ins();
         i_enable = ($urandom_range(3) != 0);
         i_flush  = ($urandom_range(7) == 0);
         i_halt   = ($urandom_range(15) == 0);
         edge_step();
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

Pipeline register between the execute stage (ALU) and the memory stage of the MIPS datapath. It captures the ALU result and the operand-B store data, resolves conditional branches from the ALU compare output, and formats store data and byte enables for data memory. It supports debug-unit stepping (enable), hazard-unit flush, and sticky HALT propagation.

## Interface
Parameters:
- NB_REG, 32, datapath and PC width
- NB_ADDR, 5, register-file address width
- NB_BHW, 2, memory access-size code width

Ports:
- i_clock  in  1  rising-edge clock
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  advance strobe from the debug unit; 0 = hold all state
- i_flush  in  1  insert bubble on next enabled edge
- i_valid  in  1  EX stage holds a real instruction
- i_alu_result  in  NB_REG  ALU result; memory address for loads and stores
- i_store_data  in  NB_REG  forwarded rt value
- i_write_reg  in  NB_ADDR  destination register
- i_pc_branch  in  NB_REG  computed branch target
- i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg, i_branch, i_halt  in  1 each  control bits
- i_bhw  in  NB_BHW  access size: 00 byte, 01 half, 11 word, 10 reserved (treated as word)
- o_alu_result, o_store_data, o_pc_branch  out  NB_REG  registered
- o_write_reg  out  NB_ADDR  registered
- o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg  out  1 each  registered
- o_byte_en  out  4  registered write byte enables
- o_bhw  out  NB_BHW  registered size
- o_branch_taken  out  1  registered PC-source select
- o_misaligned  out  1  registered alignment fault
- o_valid, o_halt  out  1 each  registered

## Operation
- Edge priority: i_reset > halted hold > (i_enable=0 hold) > i_flush > load.
- Reset: every output 0, including data buses.
- Flush (i_enable=1, i_flush=1): every control output, o_byte_en, o_valid, o_branch_taken and o_misaligned are 0; data buses are 0. i_halt is not captured.
- Load: all fields are captured. Control bits are ANDed with i_valid.
- Branch: taken = i_valid & i_branch & i_alu_result[0]. The ALU BEQ/BNE codes return 1 when the condition holds. o_zero is not used.
- Alignment: the fault is half with addr[0]=1, or word with addr[1:0]≠0, where addr = i_alu_result[1:0]. It is flagged only when mem_read or mem_write is set. On a fault, o_misaligned=1, o_mem_write=0, o_mem_read=0 and o_byte_en=0.
- Store formatting:
  - byte: data {4{d[7:0]}}, enable 0001<<addr
  - half: data {2{d[15:0]}}, enable 0011<<addr
  - word: data passed through, enable 1111
  - o_byte_en is 0 when no store.
- Halt: when a valid instruction with i_halt=1 is loaded, o_halt=1 next cycle. From then on, state freezes (enable and flush ignored) until i_reset.

## Timing
- Latency: one enabled i_clock edge from EX inputs to all outputs. No combinational input-to-output path.
- i_enable=0: outputs are stable indefinitely. A flush asserted while disabled has no effect; the hazard unit holds it until an enabled edge.
- Reset mid-halt clears o_halt on that edge; normal loading resumes on the next edge.
- Simultaneous i_flush and valid i_halt: flush wins and o_halt stays 0.
- Back-to-back enabled edges load a new instruction each cycle; there is no bubble insertion beyond flush.

## Structure
- Shared package (mips_pkg) holds:
  - BHW encodings (BHW_BYTE, BHW_HALF, BHW_WORD)
  - NB_REG, NB_ADDR, NB_BHW defaults
  - NB_BYTE_EN=4
- One combinational sub-module, store_formatter. Inputs: data, bhw, addr[1:0], store flag. Outputs: formatted data, byte enables, misaligned flag.
- Sequential priority logic lives in ex_mem_reg.

## Test plan
- Reset is held for 2 edges with inputs non-zero -> all outputs 0. After release with i_enable=0, outputs stay 0.
- Byte store: addr 0x1003, data 0xAABBCCDD, bhw 00, enable -> o_store_data 0xDDDDDDDD, o_byte_en 1000, o_mem_write 1.
- Half store at addr 0x1001 -> o_misaligned 1, o_mem_write 0, o_byte_en 0000. A word load at 0x1004 -> o_misaligned 0, o_mem_read 1.
- BEQ: i_branch=1, i_alu_result=1, i_pc_branch 0x40 -> o_branch_taken 1, o_pc_branch 0x40. Same with i_alu_result=0, or with i_valid=0 -> o_branch_taken 0.
- Flush and valid halt on the same enabled edge -> bubble (all controls 0, o_halt 0). Halt on the next edge -> o_halt 1. Outputs then stay frozen for 10 edges despite new inputs and flush; i_reset clears them.
- i_enable low for 5 cycles with changing inputs -> outputs unchanged. The first enabled edge captures the current inputs.
